cram_arbiter: RTL and testbench
===============================

CRAM_ARBITER -- requirements
Module: cram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive cycles a pending CPU access may be denied before it is forced.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_N  input  1  asynchronous, active-low reset.
REQ-004 pix_req  input  1  pixel-fetch request strobe (VCE pixel clock enable).
REQ-005 pix_addr  input  9  palette index (VDC VD bus).
REQ-006 pix_valid  output  1  pixel data valid strobe.
REQ-007 pix_data  output  9  palette entry (GGGRRRBBB).
REQ-008 pix_artifact  output  1  pix_data is a repeated stale value (CPU stole the slot).
REQ-009 cpu_req  input  1  CPU access request, sampled only while cpu_busy is low.
REQ-010 cpu_we  input  1  1 = write, 0 = read.
REQ-011 cpu_addr  input  9  CRAM address (CTA).
REQ-012 cpu_wdata  input  9  write data ({D[0], CTW}).
REQ-013 cpu_busy  output  1  request held pending; new requests ignored.
REQ-014 cpu_ack  output  1  single-cycle completion pulse.
REQ-015 cpu_rdata  output  9  read data, valid from cpu_ack until next read completion.
REQ-016 ram_addr, ram_we, ram_wdata  output  9/1/9  single-port CRAM control, combinational from the current-cycle grant.
REQ-017 ram_rdata  input  9  CRAM read data, valid the cycle after the address.

Function
REQ-018 Exactly one CRAM access per cycle; ram_we high only on a granted CPU write.
REQ-019 A request is accepted when cpu_req=1 and cpu_busy=0: addr/we/wdata are latched into a one-entry holding register, and cpu_busy goes high the next cycle.
REQ-020 CPU FSM states: IDLE, WAIT (pending), RDRESP (read issued, capturing data); IDLE->WAIT on acceptance, WAIT->IDLE on write grant, WAIT->RDRESP on read grant, RDRESP->IDLE unconditionally.
REQ-021 force = (wait_cnt == STARVE_LIMIT); grant_cpu = WAIT & (~pix_req | force); grant_pix = pix_req & ~grant_cpu.
REQ-022 wait_cnt increments each cycle the FSM is in WAIT and not granted, saturating at STARVE_LIMIT; it clears on grant and in IDLE.
REQ-023 Pixel latency: on grant_pix in cycle N, pix_valid=1 and pix_data=ram_rdata in cycle N+1, with pix_artifact=0.
REQ-024 pix_req denied in cycle N: in N+1 pix_valid=1, pix_data=last delivered value, pix_artifact=1.
REQ-025 CPU write granted in N: cpu_ack=1 in N+1.
REQ-026 CPU read granted in N: ram_rdata is captured into cpu_rdata at the end of N+1, and cpu_ack=1 in N+2.
REQ-027 cpu_busy is high from the cycle after acceptance through the cycle before cpu_ack; a new request is acceptable in the cpu_ack cycle.
REQ-028 Back-to-back same-address write then read returns the written value; no bypass path is required.
REQ-029 cpu_req while cpu_busy=1 has no effect, and the held request is not modified.

Reset
REQ-030 Reset state: FSM=IDLE, wait_cnt=0, holding register=0.
REQ-031 Reset values: pix_valid=0, pix_data=0, pix_artifact=0, cpu_busy=0, cpu_ack=0, cpu_rdata=0.
REQ-032 Reset asserted mid-operation discards the pending access: no ack and no write are issued after release.

Structure
REQ-033 Package vce_pkg holds cram_addr_t (9b), cram_data_t (9b), the CPU FSM state enum and the STARVE_LIMIT default.
REQ-034 The block is a single module without sub-modules; the CRAM array is external.

Verification
REQ-035 Scenario 1: pix_req every cycle, no CPU traffic, pix_addr=0x1A5 with RAM[0x1A5]=0x0F3 -> next cycle pix_valid=1, pix_data=0x0F3, pix_artifact=0.
REQ-036 Scenario 2: pix_req low, CPU write addr 0x010 data 0x1FF -> ram_we=1 in the grant cycle; cpu_ack one cycle later; subsequent read returns 0x1FF with ack two cycles after grant.
REQ-037 Scenario 3: pix_req held high, CPU read pending, STARVE_LIMIT=4 -> grant after 4 denied cycles; next cycle pix_artifact=1 with the previous pix_data repeated; wait_cnt returns to 0.
REQ-038 Scenario 4: cpu_req pulsed again while cpu_busy=1 with a different address -> ignored; only the first access is performed and acked.
REQ-039 Scenario 5: reset_N asserted while in WAIT with a write pending -> after release cpu_ack never pulses, ram_we stays 0, and all outputs hold their reset values.
REQ-040 Scenario 6: pix_req at 1/2 duty with continuous CPU reads -> every CPU read completes in the gaps, and pix_artifact is never asserted.

Source files
------------

// File: rtl/vce_pkg.sv
// Shared types for the VCE colour-RAM path: CRAM address/data widths, CPU port FSM
// states and the default CPU starvation bound.
package vce_pkg;

  typedef logic [8:0] cram_addr_t;
  typedef logic [8:0] cram_data_t;

  typedef enum logic [1:0] {
    CPU_IDLE   = 2'd0,
    CPU_WAIT   = 2'd1,
    CPU_RDRESP = 2'd2
  } cpu_state_e;

  typedef struct packed {
    logic       we;
    cram_addr_t addr;
    cram_data_t wdata;
  } cpu_hold_t;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/cram_arbiter.sv
// Single-port CRAM arbiter: pixel fetch has priority every cycle, and a pending CPU
// access is forced through once it has been denied STARVE_LIMIT consecutive cycles.
module cram_arbiter
  import vce_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       pix_req,
  input  cram_addr_t pix_addr,
  output logic       pix_valid,
  output cram_data_t pix_data,
  output logic       pix_artifact,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  cram_addr_t cpu_addr,
  input  cram_data_t cpu_wdata,
  output logic       cpu_busy,
  output logic       cpu_ack,
  output cram_data_t cpu_rdata,
  output cram_addr_t ram_addr,
  output logic       ram_we,
  output cram_data_t ram_wdata,
  input  cram_data_t ram_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  cpu_state_e r_state, w_state_nxt;
  cpu_hold_t  r_hold;
  logic [CW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic       r_ack;
  cram_data_t r_rdata;
  logic       r_pix_req, r_pix_gnt;
  cram_data_t r_pix_last;

  logic w_accept, w_force, w_grant_cpu, w_grant_pix;

  assign w_accept    = cpu_req & (r_state == CPU_IDLE);
  assign w_force     = (r_wait_cnt == CW'(STARVE_LIMIT));
  assign w_grant_cpu = (r_state == CPU_WAIT) & (~pix_req | w_force);
  assign w_grant_pix = pix_req & ~w_grant_cpu;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    case (r_state)
      CPU_IDLE:   if (w_accept) w_state_nxt = CPU_WAIT;
      CPU_WAIT: begin
        if (w_grant_cpu) w_state_nxt = r_hold.we ? CPU_IDLE : CPU_RDRESP;
        else if (!w_force) w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        else w_wait_cnt_nxt = r_wait_cnt;
      end
      CPU_RDRESP: w_state_nxt = CPU_IDLE;
      default:    w_state_nxt = CPU_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_state    <= CPU_IDLE;
      r_wait_cnt <= '0;
      r_hold     <= '0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_pix_req  <= 1'b0;
      r_pix_gnt  <= 1'b0;
      r_pix_last <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) r_hold <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
      r_ack      <= (w_grant_cpu & r_hold.we) | (r_state == CPU_RDRESP);
      if (r_state == CPU_RDRESP) r_rdata <= ram_rdata;
      r_pix_req  <= pix_req;
      r_pix_gnt  <= w_grant_pix;
      // Remember the last real pixel so a stolen slot can repeat it.
      if (r_pix_gnt) r_pix_last <= ram_rdata;
    end
  end

  assign ram_addr     = w_grant_cpu ? r_hold.addr : pix_addr;
  assign ram_we       = w_grant_cpu & r_hold.we;
  assign ram_wdata    = ram_we ? r_hold.wdata : '0;

  assign pix_valid    = r_pix_req;
  assign pix_data     = r_pix_gnt ? ram_rdata : r_pix_last;
  assign pix_artifact = r_pix_req & ~r_pix_gnt;

  assign cpu_busy     = (r_state != CPU_IDLE);
  assign cpu_ack      = r_ack;
  assign cpu_rdata    = r_rdata;

endmodule

// File: tb/tb_cram_arbiter.sv
// Directed bench for cram_arbiter with a behavioural single-port CRAM model.
module tb_cram_arbiter;

  logic       clock = 1'b0;
  logic       reset_N;
  logic       pix_req;
  logic [8:0] pix_addr;
  logic       pix_valid;
  logic [8:0] pix_data;
  logic       pix_artifact;
  logic       cpu_req, cpu_we;
  logic [8:0] cpu_addr, cpu_wdata;
  logic       cpu_busy, cpu_ack;
  logic [8:0] cpu_rdata;
  logic [8:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_we;

  logic       init;
  logic [8:0] mem [512];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  cram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_N(reset_N),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_artifact(pix_artifact),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [8:0] rom(input logic [8:0] a);
    case (a)
      9'h1A5:  rom = 9'h0F3;
      9'h020:  rom = 9'h055;
      9'h030:  rom = 9'h0AA;
      default: rom = a ^ 9'h15A;
    endcase
  endfunction

  always @(posedge clock) begin
    if (init) begin
      for (int i = 0; i < 512; i++) mem[i] <= rom(9'(i));
      ram_rdata <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clock);
  endtask

  logic [8:0] q[$];
  logic [8:0] a_exp;
  int bad, n_ack;

  initial begin
    reset_N = 1'b0; init = 1'b1;
    pix_req = 0; pix_addr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;

    // reset state
    cyc; #1;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_art", pix_artifact, 0);
    chk("rst_busy", cpu_busy, 0);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rdata", cpu_rdata, 0);
    cyc; init = 1'b0; reset_N = 1'b1;

    // scenario 1: pixel fetch
    cyc; pix_req = 1; pix_addr = 9'h1A5; #1;
    chk("s1_ram_addr", ram_addr, 9'h1A5);
    chk("s1_ram_we", ram_we, 0);
    cyc; #1;
    chk("s1_valid", pix_valid, 1);
    chk("s1_data", pix_data, 9'h0F3);
    chk("s1_art", pix_artifact, 0);
    cyc; pix_req = 0; #1;
    chk("s1_data2", pix_data, 9'h0F3);

    // scenario 2: write then read same address
    cyc; cpu_req = 1; cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 9'h1FF; #1;
    chk("s2_busy_acc", cpu_busy, 0);
    cyc; cpu_req = 0; #1;
    chk("s2_busy_w", cpu_busy, 1);
    chk("s2_ram_we", ram_we, 1);
    chk("s2_ram_addr", ram_addr, 9'h010);
    chk("s2_ram_wdata", ram_wdata, 9'h1FF);
    chk("s2_ack_early", cpu_ack, 0);
    chk("s2_pix_valid0", pix_valid, 0);
    cyc; cpu_req = 1; cpu_we = 0; cpu_wdata = 0; #1;
    chk("s2_wack", cpu_ack, 1);
    chk("s2_wack_busy", cpu_busy, 0);
    cyc; cpu_req = 0; #1;
    chk("s2_rgrant_addr", ram_addr, 9'h010);
    chk("s2_rgrant_we", ram_we, 0);
    chk("s2_rbusy", cpu_busy, 1);
    chk("s2_rack0", cpu_ack, 0);
    cyc; #1;
    chk("s2_rresp_busy", cpu_busy, 1);
    chk("s2_rresp_ack", cpu_ack, 0);
    cyc; #1;
    chk("s2_rack", cpu_ack, 1);
    chk("s2_rdata", cpu_rdata, 9'h1FF);
    chk("s2_rack_busy", cpu_busy, 0);
    cyc; #1;
    chk("s2_ack_pulse", cpu_ack, 0);

    // scenario 3: starvation forcing, twice to show the counter clears
    cyc; pix_req = 1; pix_addr = 9'h1A5; cpu_req = 1; cpu_we = 0; cpu_addr = 9'h020; #1;
    chk("s3_acc_addr", ram_addr, 9'h1A5);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        cyc; cpu_req = 0; #1;
        chk($sformatf("s3_deny%0d_%0d", r, i), ram_addr, 9'h1A5);
        chk($sformatf("s3_art0_%0d_%0d", r, i), pix_artifact, 0);
        chk($sformatf("s3_pdata_%0d_%0d", r, i), pix_data, 9'h0F3);
      end
      cyc; #1;
      chk($sformatf("s3_force%0d", r), ram_addr, (r == 0) ? 9'h020 : 9'h030);
      cyc; #1;
      chk($sformatf("s3_art1_%0d", r), pix_artifact, 1);
      chk($sformatf("s3_valid_%0d", r), pix_valid, 1);
      chk($sformatf("s3_stale_%0d", r), pix_data, 9'h0F3);
      cyc;
      if (r == 0) begin cpu_req = 1; cpu_addr = 9'h030; end
      #1;
      chk($sformatf("s3_ack%0d", r), cpu_ack, 1);
      chk($sformatf("s3_rdata%0d", r), cpu_rdata, (r == 0) ? 9'h055 : 9'h0AA);
      chk($sformatf("s3_art_after%0d", r), pix_artifact, 0);
    end

    // scenario 4: request while busy is ignored
    cyc; cpu_req = 1; cpu_we = 1; cpu_addr = 9'h040; cpu_wdata = 9'h111; #1;
    chk("s4_busy0", cpu_busy, 0);
    cyc; cpu_addr = 9'h041; cpu_wdata = 9'h1EE; #1;
    chk("s4_busy1", cpu_busy, 1);
    chk("s4_we_denied", ram_we, 0);
    cyc; cpu_req = 0; pix_req = 0; #1;
    chk("s4_we", ram_we, 1);
    chk("s4_addr", ram_addr, 9'h040);
    chk("s4_wdata", ram_wdata, 9'h111);
    cyc; #1;
    chk("s4_ack", cpu_ack, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cyc; #1;
      if (ram_we || cpu_ack || cpu_busy) bad++;
    end
    chk("s4_no_extra", bad, 0);
    chk("s4_mem040", mem[9'h040], 9'h111);
    chk("s4_mem041", mem[9'h041], rom(9'h041));

    // scenario 5: reset discards a pending write
    cyc; pix_req = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 9'h050; cpu_wdata = 9'h123; #1;
    cyc; cpu_req = 0; #1;
    chk("s5_busy", cpu_busy, 1);
    cyc; reset_N = 0; #1;
    chk("s5_rst_busy", cpu_busy, 0);
    chk("s5_rst_we", ram_we, 0);
    chk("s5_rst_pdata", pix_data, 0);
    chk("s5_rst_rdata", cpu_rdata, 0);
    cyc;
    cyc; reset_N = 1; pix_req = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cyc; #1;
      if (ram_we || cpu_ack || cpu_busy || pix_valid || pix_artifact ||
          pix_data != 0 || cpu_rdata != 0) bad++;
    end
    chk("s5_quiet", bad, 0);
    chk("s5_mem050", mem[9'h050], rom(9'h050));

    // scenario 6: half-duty pixel fetch with continuous CPU reads
    n_ack = 0; bad = 0;
    for (int k = 0; k < 44; k++) begin
      cyc;
      pix_req = (k % 2 == 0) && (k < 40);
      pix_addr = 9'h1A5;
      cpu_req = (k < 40); cpu_we = 0; cpu_addr = 9'(9'h100 + k);
      #1;
      if (pix_artifact) bad++;
      if (cpu_ack) begin
        n_ack++;
        if (q.size() == 0) chk("s6_spurious_ack", 1, 0);
        else begin
          a_exp = q.pop_front();
          chk($sformatf("s6_rdata_%0h", a_exp), cpu_rdata, rom(a_exp));
        end
      end
      if (cpu_req && !cpu_busy) q.push_back(cpu_addr);
    end
    chk("s6_no_artifact", bad, 0);
    chk("s6_enough_acks", (n_ack >= 8), 1);
    chk("s6_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
